// File: rtl/led_pulse_stretch.sv
// Per-channel LED pulse stretcher: widens short event pulses to at least HOLD_CYCLES clocks.
// Optional build macro PULSE_STRETCH_COUNT_EN adds saturating per-channel event counters.
//
// state  | meaning
// IDLE   | LED off, waiting for a registered input pulse
// ACTIVE | LED on, hold counter running down (reloaded while input stays high)
module led_pulse_stretch #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 500000,
    parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   pulse_in,
    output logic [CHANNELS-1:0]   led_out,
    output logic                  busy
`ifdef PULSE_STRETCH_COUNT_EN
    ,
    input  logic                  evt_clr,
    output logic [8*CHANNELS-1:0] evt_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CHANNELS-1:0] in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= pulse_in;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;

        // Reload takes priority over the terminal-count exit so overlapping holds never gap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state      <= IDLE;
                cnt        <= '0;
                led_out[i] <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_q[i]) begin
                            state      <= ACTIVE;
                            cnt        <= RELOAD;
                            led_out[i] <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (in_q[i]) begin
                            cnt <= RELOAD;
                        end else if (cnt == '0) begin
                            state      <= IDLE;
                            led_out[i] <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        led_out[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = |led_out;

`ifdef PULSE_STRETCH_COUNT_EN
    logic [CHANNELS-1:0] in_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_qq <= '0;
        end else begin
            in_qq <= in_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_evt
        logic [7:0] evt_cnt;
        logic       rise;

        assign rise = in_q[i] & ~in_qq[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                evt_cnt <= '0;
            end else if (evt_clr) begin
                evt_cnt <= '0;
            end else if (rise && (evt_cnt != 8'hFF)) begin
                evt_cnt <= evt_cnt + 8'd1;
            end
        end

        assign evt_count[8*i +: 8] = evt_cnt;
    end
`endif

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Scoreboard bench for led_pulse_stretch (CHANNELS=2, HOLD_CYCLES=4).
// Counter checks are compiled in only when PULSE_STRETCH_COUNT_EN is defined.
module tb_led_pulse_stretch;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pulse_in;
    logic [1:0]  led_out;
    logic        busy;
`ifdef PULSE_STRETCH_COUNT_EN
    logic        evt_clr;
    logic [15:0] evt_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    led_pulse_stretch #(
        .CHANNELS   (2),
        .HOLD_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy)
`ifdef PULSE_STRETCH_COUNT_EN
        ,
        .evt_clr  (evt_clr),
        .evt_count(evt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected {led_out} per clock edge while the queue holds entries.
    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led_busy", {13'd0, led_out, busy}, {13'd0, e, |e});
        end
    end

    // Bit k of each word is cycle k: pulse driven before edge k+1, led expected after it.
    task automatic seq(input int n, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] e0, input logic [31:0] e1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pulse_in = {p1[k], p0[k]};
            exp_q.push_back({e1[k], e0[k]});
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pulse_in = 2'b11;
`ifdef PULSE_STRETCH_COUNT_EN
        evt_clr  = 1'b0;
`endif
        // Reset held with inputs high, then release with inputs still high.
        seq(3, 32'h7, 32'h7, 32'h0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        seq(8, 32'h3, 32'h3, 32'h3E, 32'h3E);

        // Single pulse, long pulse, retrigger, independence, reload at cnt==0, gap.
        seq(8,  32'h1, 32'h0,  32'h1E,  32'h0);
        seq(12, 32'h0, 32'h3F, 32'h0,   32'h3FE);
        seq(10, 32'h9, 32'h0,  32'hFE,  32'h0);
        seq(9,  32'h1, 32'h4,  32'h1E,  32'h78);
        seq(11, 32'h11, 32'h0, 32'h1FE, 32'h0);
        seq(12, 32'h21, 32'h0, 32'h3DE, 32'h0);

        // Asynchronous reset two cycles into a hold.
        seq(3, 32'h1, 32'h0, 32'h6, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", {14'd0, led_out}, 16'd0);
        check("async_busy", {15'd0, busy}, 16'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seq(6, 32'h0, 32'h0, 32'h0, 32'h0);

`ifdef PULSE_STRETCH_COUNT_EN
        @(negedge clk);
        check("cnt_after_reset", evt_count, 16'd0);
        for (int p = 0; p < 300; p++) begin
            @(negedge clk) pulse_in = 2'b01;
            @(negedge clk) pulse_in = 2'b00;
            @(negedge clk);
            if (p == 9) begin
                @(negedge clk);
                check("cnt_ten", evt_count, 16'h000A);
            end
        end
        repeat (3) @(negedge clk);
        check("cnt_saturate", evt_count, 16'h00FF);
        pulse_in = 2'b01;
        @(negedge clk);
        pulse_in = 2'b00;
        evt_clr  = 1'b1;
        @(negedge clk);
        evt_clr  = 1'b0;
        repeat (2) @(negedge clk);
        check("cnt_clr_wins", evt_count, 16'h0000);
        pulse_in = 2'b01;
        @(negedge clk);
        pulse_in = 2'b00;
        repeat (3) @(negedge clk);
        check("cnt_after_clr", evt_count, 16'h0001);
        repeat (8) @(negedge clk);
`endif

        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
